mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 197 +++++++++++++++++++
 tb/tb_mc_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/writeback strobes per instruction.
// Latency: outputs are decoded from the current state in the same cycle; lw 5, sw/R/addi 4, beq/j 3, bad opcode 2 cycles.
// Backpressure: none. The FSM advances every clock, and reset abandons the current instruction on the next edge.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       instruction fields [31:26] and [5:0] from the instruction register
//   zout                ALU zero flag, used combinationally in BEQ
//   alu_control         ALU operation select
//   alusrca, alusrcb    ALU operand selects
//   pcsrc, pc_en        PC source select and PC write enable
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite   datapath strobes and selects
//   illegal             one-cycle pulse on an unsupported opcode or funct
//   state               current state encoding, for debug
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zout,
  output logic [2:0] alu_control,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d     = FETCH;
    alu_control = ALU_ADD;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        pc_en   = 1'b1;
        irwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Only lw and sw reach here, so anything not lw is treated as sw.
        state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = FETCH;
      end
      EXEC: begin
        alusrca = 1'b1;
        state_d = RTWB;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b100111: alu_control = ALU_NOR;
          6'b000000: alu_control = ALU_SLL;
          6'b000010: alu_control = ALU_SRL;
          default: begin
            // Drop the instruction without writeback.
            alu_control = ALU_ADD;
            illegal     = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        alusrca     = 1'b1;
        alu_control = ALU_SUB;
        pcsrc       = 2'b01;
        pc_en       = zout;
        state_d     = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pc_en   = 1'b1;
        state_d = FETCH;
      end
      default: begin
        // Encodings 12-15 recover to FETCH with every strobe idle.
        state_d = FETCH;
      end
    endcase

    // Reset suppresses every architectural side effect in the current cycle.
    if (reset) begin
      pc_en    = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zout;
  logic [2:0] alu_control;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mc_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zout        (zout),
    .alu_control (alu_control),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .pc_en       (pc_en),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Observed vector: alu[19:17] a[16] b[15:14] pcsrc[13:12]
  // {pc_en,iord,memwrite,irwrite,regdst,memtoreg,regwrite,illegal}[11:4] state[3:0]
  logic [19:0] obs;
  assign obs = {alu_control, alusrca, alusrcb, pcsrc,
                pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal,
                state};

  function automatic logic [19:0] ev(input logic [2:0] alu, input logic a,
                                     input logic [1:0] b, input logic [1:0] pcs,
                                     input logic [7:0] strb, input logic [3:0] st);
    return {alu, a, b, pcs, strb, st};
  endfunction

  // Step past the next rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h (state %0d vs %0d)",
             tag, obs, exp, obs[3:0], exp[3:0]);
    end
  endtask

  // Strobe byte order: pc_en iord memwrite irwrite regdst memtoreg regwrite illegal
  logic [19:0] E_FETCH, E_FETCH_RST, E_DECODE, E_DECODE_ILL, E_MEMADR, E_MEMRD, E_MEMWB,
               E_MEMWR, E_MEMWR_RST, E_RTWB, E_ADDIEX, E_ADDIWB, E_JUMP;

  initial begin
    E_FETCH      = ev(3'b010, 1'b0, 2'b01, 2'b00, 8'b1001_0000, 4'd0);
    E_FETCH_RST  = ev(3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000, 4'd0);
    E_DECODE     = ev(3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000, 4'd1);
    E_DECODE_ILL = ev(3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0001, 4'd1);
    E_MEMADR     = ev(3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000, 4'd2);
    E_MEMRD      = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0100_0000, 4'd3);
    E_MEMWB      = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0110, 4'd4);
    E_MEMWR      = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0110_0000, 4'd5);
    E_MEMWR_RST  = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0100_0000, 4'd5);
    E_RTWB       = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_1010, 4'd7);
    E_ADDIEX     = ev(3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000, 4'd9);
    E_ADDIWB     = ev(3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0010, 4'd10);
    E_JUMP       = ev(3'b010, 1'b0, 2'b00, 2'b10, 8'b1000_0000, 4'd11);

    reset  = 1'b1;
    opcode = 6'b100011;
    funct  = 6'b000000;
    zout   = 1'b0;

    // Reset: FETCH state with side-effect strobes forced low.
    tick(); tick();
    chk("reset_hold", E_FETCH_RST);
    reset = 1'b0;
    chk("fetch_after_reset", E_FETCH);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_decode", E_DECODE);
    tick(); chk("lw_memadr", E_MEMADR);
    tick(); chk("lw_memrd",  E_MEMRD);
    tick(); chk("lw_memwb",  E_MEMWB);
    tick(); chk("lw_fetch",  E_FETCH);

    // R-type sub
    opcode = 6'b000000; funct = 6'b100010;
    tick(); chk("sub_decode", E_DECODE);
    tick(); chk("sub_exec", ev(3'b110, 1'b1, 2'b00, 2'b00, 8'b0, 4'd6));
    tick(); chk("sub_rtwb", E_RTWB);
    tick(); chk("sub_fetch", E_FETCH);

    // R-type srl
    funct = 6'b000010;
    tick(); chk("srl_decode", E_DECODE);
    tick(); chk("srl_exec", ev(3'b101, 1'b1, 2'b00, 2'b00, 8'b0, 4'd6));
    tick(); chk("srl_rtwb", E_RTWB);
    tick(); chk("srl_fetch", E_FETCH);

    // R-type and / sll (other funct mappings)
    funct = 6'b100100;
    tick(); tick(); chk("and_exec", ev(3'b000, 1'b1, 2'b00, 2'b00, 8'b0, 4'd6));
    tick(); tick(); chk("and_fetch", E_FETCH);
    funct = 6'b000000;
    tick(); tick(); chk("sll_exec", ev(3'b100, 1'b1, 2'b00, 2'b00, 8'b0, 4'd6));
    tick(); tick();

    // beq taken, then zout toggled combinationally in the same cycle
    opcode = 6'b000100; zout = 1'b1;
    tick(); chk("beq_decode", E_DECODE);
    tick(); chk("beq_taken", ev(3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000, 4'd8));
    zout = 1'b0;
    chk("beq_not_taken", ev(3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000, 4'd8));
    tick(); chk("beq_fetch", E_FETCH);

    // addi
    opcode = 6'b001000;
    tick(); chk("addi_decode", E_DECODE);
    tick(); chk("addi_ex", E_ADDIEX);
    tick(); chk("addi_wb", E_ADDIWB);
    tick(); chk("addi_fetch", E_FETCH);

    // j: 0,1,11,0
    opcode = 6'b000010;
    tick(); chk("j_decode", E_DECODE);
    tick(); chk("j_jump", E_JUMP);
    tick(); chk("j_fetch", E_FETCH);

    // Illegal opcode: 2-cycle instruction
    opcode = 6'b111111;
    tick(); chk("badop_decode", E_DECODE_ILL);
    tick(); chk("badop_fetch", E_FETCH);

    // Illegal funct: no RTWB
    opcode = 6'b000000; funct = 6'b111111;
    tick(); chk("badfn_decode", E_DECODE);
    tick(); chk("badfn_exec", ev(3'b010, 1'b1, 2'b00, 2'b00, 8'b0000_0001, 4'd6));
    tick(); chk("badfn_fetch", E_FETCH);

    // sw with reset during MEMADR
    opcode = 6'b101011;
    tick(); chk("sw_decode", E_DECODE);
    tick(); chk("sw_memadr", E_MEMADR);
    reset = 1'b1;
    tick(); chk("sw_rst_fetch", E_FETCH_RST);
    reset = 1'b0;
    chk("sw_refetch", E_FETCH);

    // Full sw: 4 cycles
    tick(); chk("sw2_decode", E_DECODE);
    tick(); chk("sw2_memadr", E_MEMADR);
    tick(); chk("sw2_memwr",  E_MEMWR);
    tick(); chk("sw2_fetch",  E_FETCH);

    // Reset landing in MEMWR suppresses memwrite
    tick(); tick(); tick();
    chk("sw3_memwr", E_MEMWR);
    reset = 1'b1;
    chk("sw3_memwr_rst", E_MEMWR_RST);
    tick(); chk("sw3_rst_fetch", E_FETCH_RST);
    reset = 1'b0;
    chk("sw3_refetch", E_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
